// File: rtl/la_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the logic-analyzer register slave.
// Round-robin grant per bus cycle, with a watchdog that aborts stalled transfers.
module la_wb_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,

  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT   = 2'd1,
    ABORT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  logic             g_q;
  logic             last_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             gCyc;
  logic             gStb;
  logic             gWe;
  logic [3:0]       gSel;
  logic [31:0]      gAdr;
  logic [31:0]      gDat;

  assign gCyc  = g_q ? m1_cyc_i : m0_cyc_i;
  assign gStb  = g_q ? m1_stb_i : m0_stb_i;
  assign gWe   = g_q ? m1_we_i  : m0_we_i;
  assign gSel  = g_q ? m1_sel_i : m0_sel_i;
  assign gAdr  = g_q ? m1_adr_i : m0_adr_i;
  assign gDat  = g_q ? m1_dat_i : m0_dat_i;
  assign cnt_d = cnt_q + CNT_W'(1);

  // Ack is checked before the watchdog limit so a last-moment ack still completes the beat.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      g_q     <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (m0_cyc_i || m1_cyc_i) begin
            state_q <= GNT;
            if (m0_cyc_i && m1_cyc_i) begin
              g_q <= ~last_q;
            end else begin
              g_q <= m1_cyc_i;
            end
          end
        end
        GNT: begin
          if (!gCyc) begin
            state_q <= IDLE;
            last_q  <= g_q;
            cnt_q   <= '0;
          end else if (s_ack_i || !gStb) begin
            cnt_q <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= ABORT;
            err_q   <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ABORT: begin
          cnt_q <= '0;
          if (!gCyc) begin
            state_q <= IDLE;
            last_q  <= g_q;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Slave side only ever sees the granted master; s_ack_i never feeds back into s_*_o.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_dat_o = '0;
    if (state_q == GNT) begin
      s_cyc_o = gCyc;
      s_stb_o = gStb;
      s_we_o  = gWe;
      s_sel_o = gSel;
      s_adr_o = gAdr;
      s_dat_o = gDat;
      if (g_q) begin
        m1_ack_o = s_ack_i;
        m1_dat_o = s_dat_i;
      end else begin
        m0_ack_o = s_ack_i;
        m0_dat_o = s_dat_i;
      end
    end
  end

  assign m0_err_o = err_q & ~g_q;
  assign m1_err_o = err_q &  g_q;

  always_comb begin
    gnt_o = 2'b00;
    if (state_q != IDLE) begin
      gnt_o = g_q ? 2'b10 : 2'b01;
    end
  end

endmodule
